// File: rtl/stream_extremum.sv
// stream_extremum: finds the max or min (unsigned or signed) of a stream of len samples,
// with the 0-based index of its first occurrence.
// Ports: start/mode/len launch a search; in_valid/in_data/in_ready form the sample handshake;
// busy, done (1-cycle pulse), empty, result and result_idx report status and outcome.
module stream_extremum #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic              empty,
  output logic [DATA_W-1:0] result,
  output logic [CNT_W-1:0]  result_idx
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [CNT_W-1:0]    idx_q, idx_d;
  logic                empty_q, empty_d;

  logic                gt;
  logic                lt;
  logic                better;
  logic                accept;

  assign accept = (state_q == S_RUN) && in_valid;

  // Strict comparisons only, so an equal later sample never displaces the first one.
  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    if (mode_q[1]) begin
      gt = $signed(in_data) > $signed(result_q);
      lt = $signed(in_data) < $signed(result_q);
    end else begin
      gt = in_data > result_q;
      lt = in_data < result_q;
    end
    better = mode_q[0] ? lt : gt;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    mode_d   = mode_q;
    result_d = result_q;
    idx_d    = idx_q;
    empty_d  = empty_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d  = len;
          mode_d = mode;
          cnt_d  = '0;
          if (len == '0) begin
            state_d  = S_DONE;
            result_d = '0;
            idx_d    = '0;
            empty_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            empty_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          // First sample loads unconditionally; result_q still holds the previous search here.
          if ((cnt_q == '0) || better) begin
            result_d = in_data;
            idx_d    = cnt_q;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      mode_q   <= '0;
      result_q <= '0;
      idx_q    <= '0;
      empty_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      empty_q  <= empty_d;
    end
  end

  // All status outputs decode the registered state, so reset clears them immediately.
  assign in_ready   = (state_q == S_RUN);
  assign busy       = in_ready;
  assign done       = (state_q == S_DONE);
  assign empty      = empty_q;
  assign result     = result_q;
  assign result_idx = idx_q;

endmodule

// File: tb/tb_stream_extremum.sv
module tb_stream_extremum;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic       empty;
  logic [7:0] result;
  logic [7:0] result_idx;

  stream_extremum #(.DATA_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .len        (len),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .busy       (busy),
    .done       (done),
    .empty      (empty),
    .result     (result),
    .result_idx (result_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [7:0] idx;
    logic       emp;
    int         lat;
    int         start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  bit   lenzero = 1'b0;

  logic [7:0] buf_d [0:255];
  int         stl   [0:255];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Reference: find the extreme value over the whole stream, then its first position.
  function automatic void model(input logic [1:0] m, input int n,
                                output logic [7:0] res, output logic [7:0] idx);
    int v [0:255];
    int ext;
    res = 8'h00;
    idx = 8'h00;
    if (n == 0) return;
    for (int i = 0; i < n; i++)
      v[i] = m[1] ? int'($signed(buf_d[i])) : int'({24'd0, buf_d[i]});
    ext = v[0];
    for (int i = 1; i < n; i++)
      if (m[0] ? (v[i] < ext) : (v[i] > ext)) ext = v[i];
    for (int i = n - 1; i >= 0; i--)
      if (v[i] == ext) begin
        res = buf_d[i];
        idx = 8'(i);
      end
  endfunction

  // Monitor: handshake sanity every cycle, result comparison on each done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_eq_ready", busy, in_ready);
      if (lenzero) check("len0_no_ready", in_ready, 0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", result, e.res);
          check("result_idx", result_idx, e.idx);
          check("empty", empty, e.emp);
          check("done_latency", cyc - e.start_cyc, e.lat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_search(input logic [1:0] m, input int n,
                            input bit rand_stall, input bit poke_start);
    exp_t e;
    int   total;
    int   g;
    total = 0;
    for (int i = 0; i < n; i++) begin
      stl[i] = rand_stall ? int'($urandom_range(0, 3)) : 0;
      total += stl[i];
    end
    model(m, n, e.res, e.idx);
    e.emp = (n == 0);
    e.lat = n + total;
    lenzero = (n == 0);
    start = 1'b1;
    mode  = m;
    len   = 8'(n);
    tick();
    start = 1'b0;
    // Scramble the launch inputs; the search must use the latched copies.
    mode  = ~m;
    len   = 8'($urandom);
    e.start_cyc = cyc;
    sb.push_back(e);
    last_exp = e;
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < stl[i]; s++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = buf_d[i];
      if (poke_start && i == 2) begin
        start = 1'b1;
        len   = 8'd0;
      end
      g = 0;
      while (!in_ready && g < 100) begin
        tick();
        g++;
      end
      if (g >= 100) check("ready_timeout", g, 0);
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
    end
    // Now in DONE (monitor checks it at the falling edge); step into IDLE.
    tick();
    lenzero = 1'b0;
    check("sb_drained", sb.size(), 0);
    check("hold_result", result, last_exp.res);
    check("hold_idx", result_idx, last_exp.idx);
    check("hold_empty", empty, last_exp.emp);
    check("idle_not_busy", busy, 0);
  endtask

  task automatic load(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                      input logic [7:0] a3, input logic [7:0] a4);
    buf_d[0] = a0; buf_d[1] = a1; buf_d[2] = a2; buf_d[3] = a3; buf_d[4] = a4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; len = 8'd0; in_valid = 1'b0; in_data = 8'd0;
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_idx", result_idx, 0);
    check("rst_empty", empty, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Unsigned max, directed.
    load(8'h0C, 8'h2D, 8'h17, 8'h43, 8'h22);
    run_search(2'b00, 5, 1'b0, 1'b0);
    check("dir_umax_res", result, 8'h43);
    check("dir_umax_idx", result_idx, 3);
    // Signed min, then unsigned min of the same stream.
    load(8'h05, 8'h80, 8'h7F, 8'hFF, 8'h00);
    run_search(2'b11, 4, 1'b0, 1'b0);
    check("dir_smin_res", result, 8'h80);
    check("dir_smin_idx", result_idx, 1);
    run_search(2'b01, 4, 1'b0, 1'b0);
    check("dir_umin_res", result, 8'h05);
    check("dir_umin_idx", result_idx, 0);
    // Ties, max: without and with stalls.
    load(8'h10, 8'h30, 8'h30, 8'h20, 8'h00);
    run_search(2'b00, 4, 1'b0, 1'b0);
    check("dir_tie_idx", result_idx, 1);
    run_search(2'b00, 4, 1'b1, 1'b0);
    check("dir_tie_stall_idx", result_idx, 1);
    // Empty search.
    run_search(2'b00, 0, 1'b0, 1'b0);
    check("dir_len0_res", result, 0);

    // Reset mid-search after 2 of 5 samples.
    load(8'h11, 8'h99, 8'h44, 8'hEE, 8'h22);
    start = 1'b1; mode = 2'b00; len = 8'd5;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = buf_d[i];
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_idx", result_idx, 0);
    check("mid_rst_empty", empty, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("post_rst_no_done", done, 0);
      tick();
    end
    // Restart, pulsing start while busy.
    run_search(2'b00, 5, 1'b1, 1'b1);
    check("restart_res", result, 8'hEE);
    check("restart_idx", result_idx, 3);

    // Randomized searches across all modes, including the maximum length.
    for (int t = 0; t < 24; t++) begin
      int n;
      n = (t == 0) ? 255 : int'($urandom_range(0, 20));
      for (int i = 0; i < n; i++)
        buf_d[i] = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom_range(0, 255));
      run_search(2'($urandom_range(0, 3)), n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    check("final_sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/stream_extremum.md
STREAM_EXTREMUM -- requirements
Module: stream_extremum

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the sample and result width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the width of the sample count and index.
Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1: in IDLE, begin a search.
REQ-006 The block SHALL have port mode, input, 2: bit0 selects 0=max or 1=min; bit1 selects 0=unsigned or 1=signed (two's complement).
REQ-007 The block SHALL have port len, input, CNT_W: the number of samples to examine.
REQ-008 The block SHALL have port in_valid, input, 1: the source offers in_data.
REQ-009 The block SHALL have port in_data, input, DATA_W: the sample value.
REQ-010 The block SHALL have port in_ready, output, 1: the block accepts a sample this cycle.
REQ-011 The block SHALL have port busy, output, 1: a search is in progress.
REQ-012 The block SHALL have port done, output, 1: one-cycle pulse that marks the result as valid.
REQ-013 The block SHALL have port empty, output, 1: the last search had len=0.
REQ-014 The block SHALL have port result, output, DATA_W: the extremum value.
REQ-015 The block SHALL have port result_idx, output, CNT_W: the 0-based position of the extremum in the stream.

Function
REQ-016 The FSM SHALL have the states IDLE, RUN and DONE.
- Encoding is free.
- The state is registered.
REQ-017 In IDLE with start=1 at a rising edge, the block SHALL latch len and mode and clear the sample counter.
- If len != 0: go to RUN.
- If len == 0: go to DONE with result=0, result_idx=0, empty=1.
REQ-018 The block SHALL drive in_ready = 1 exactly when the state is RUN, and busy SHALL equal in_ready.
REQ-019 A sample SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
- in_valid=0 stalls the search with no state change.
- There is no limit on stall length.
REQ-020 The first accepted sample SHALL load result and set result_idx=0 unconditionally.
REQ-021 Each later accepted sample SHALL replace result, and set result_idx to the current counter value, only when it is strictly greater (max) or strictly less (min) under the latched signedness.
- On equal values the first occurrence wins.
REQ-022 The counter SHALL increment on each accepted sample.
- When the accepted sample is number len (counter = len-1 before increment), the next state is DONE.
- The counter never wraps within a search.
- len = 2^CNT_W-1 is the maximum.
REQ-023 DONE SHALL last exactly one cycle with done=1 and then return to IDLE unconditionally.
REQ-024 result, result_idx and empty SHALL hold their values from DONE until the next start is accepted in IDLE.
- empty is cleared when a start with len != 0 is accepted.
REQ-025 start SHALL be ignored in RUN and DONE.
- Changes on len or mode after latching have no effect on the search in progress.
REQ-026 Latency SHALL be exactly 1 cycle from the final accepted sample to done=1.
- A stall-free search of N samples takes N+2 cycles from the start edge to the done cycle inclusive.
REQ-027 A start accepted in the same cycle that DONE returns to IDLE SHALL NOT be possible.
- The earliest new start is sampled in the first IDLE cycle after DONE.

Reset
REQ-028 While rst=1, immediately and independently of clk, the block SHALL:
- set the state to IDLE;
- force in_ready, busy, done and empty to 0;
- force result, result_idx and the counter to 0.
REQ-029 Reset asserted mid-RUN SHALL abandon the search without a done pulse.
- The first start after rst deasserts begins a fresh search.

Verification
REQ-030 Unsigned max, len=5, stream 0x0C,0x2D,0x17,0x43,0x22 with no stalls -> result=0x43, result_idx=3, done on the 7th cycle after the start edge, empty=0.
REQ-031 Signed min, len=4, stream 0x05,0x80,0x7F,0xFF -> result=0x80, result_idx=1; the same stream in unsigned min -> result=0x05, idx=0.
REQ-032 Ties, max, stream 0x10,0x30,0x30,0x20 -> result_idx=1; also toggle in_valid randomly and check the result is unchanged and done is delayed by the stall count.
REQ-033 len=0 -> done 2 cycles after start, empty=1, result=0, in_ready never asserted.
REQ-034 Assert rst for 1 cycle after 2 of 5 samples -> all outputs 0 at once, no done; restart and complete with the correct result; a start pulsed while busy is ignored.
